// File: rtl/cv32e40p_pc_redirect_sequencer.sv
// Arbitrates PC-redirect requesters into one registered fetch redirect command,
// held until IF acknowledges it, with a boot redirect and a post-redirect kill window.
module cv32e40p_pc_redirect_sequencer #(
  parameter int unsigned KILL_CYCLES = 2,
  parameter int unsigned CNT_W       = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fetch_enable_i,
  input  logic       dbg_halt_req_i,
  input  logic       dbg_exc_req_i,
  input  logic       exc_req_i,
  input  logic       irq_req_i,
  input  logic [4:0] irq_id_i,
  input  logic       trap_user_i,
  input  logic       branch_req_i,
  input  logic       jump_req_i,
  input  logic       mret_req_i,
  input  logic       uret_req_i,
  input  logic       dret_req_i,
  input  logic       fencei_req_i,
  input  logic       hwlp_req_i,
  input  logic       fetch_ack_i,
  output logic       pc_set_o,
  output logic [3:0] pc_mux_o,
  output logic [2:0] exc_pc_mux_o,
  output logic [1:0] trap_addr_mux_o,
  output logic [4:0] exc_vec_o,
  output logic [9:0] req_grant_o,
  output logic       kill_o,
  output logic       busy_o
);

  localparam logic [3:0] PcBoot      = 4'd0;
  localparam logic [3:0] PcFencei    = 4'd1;
  localparam logic [3:0] PcJump      = 4'd2;
  localparam logic [3:0] PcBranch    = 4'd3;
  localparam logic [3:0] PcException = 4'd4;
  localparam logic [3:0] PcMret      = 4'd5;
  localparam logic [3:0] PcUret      = 4'd6;
  localparam logic [3:0] PcDret      = 4'd7;
  localparam logic [3:0] PcHwloop    = 4'd8;

  localparam logic [2:0] ExcPcException = 3'd0;
  localparam logic [2:0] ExcPcIrq       = 3'd1;
  localparam logic [2:0] ExcPcDbd       = 3'd2;
  localparam logic [2:0] ExcPcDbe       = 3'd3;

  localparam logic [1:0] TrapMachine = 2'd0;

  // Request classes used for preemption of a held command
  localparam logic [1:0] ClsRest = 2'd0;
  localparam logic [1:0] ClsTrap = 2'd1;
  localparam logic [1:0] ClsDbg  = 2'd2;

  typedef enum logic [1:0] {StBootWait, StIdle, StIssue, StKill} state_e;

  state_e           state_q, state_d;
  logic             pc_set_q, pc_set_d;
  logic [3:0]       pc_mux_q, pc_mux_d;
  logic [2:0]       exc_pc_q, exc_pc_d;
  logic [1:0]       trap_q, trap_d;
  logic [4:0]       vec_q, vec_d;
  logic [1:0]       cls_q, cls_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       en_dbg, en_trap, en_rest;
  logic [9:0] grant;
  logic [3:0] new_pc_mux;
  logic [2:0] new_exc_pc;
  logic [1:0] new_trap;
  logic [4:0] new_vec;
  logic [1:0] new_cls;

  always_comb begin
    en_dbg  = 1'b0;
    en_trap = 1'b0;
    en_rest = 1'b0;
    case (state_q)
      StIdle: begin
        en_dbg  = 1'b1;
        en_trap = 1'b1;
        en_rest = 1'b1;
      end
      StKill: begin
        en_dbg  = 1'b1;
        en_trap = 1'b1;
      end
      StIssue: begin
        en_dbg  = (cls_q != ClsDbg);
        en_trap = (cls_q == ClsRest);
      end
      default: ;
    endcase
  end

  always_comb begin
    grant      = '0;
    new_pc_mux = PcException;
    new_exc_pc = ExcPcException;
    new_trap   = TrapMachine;
    new_vec    = '0;
    new_cls    = ClsRest;
    if (en_dbg && dbg_halt_req_i) begin
      grant[0]   = 1'b1;
      new_exc_pc = ExcPcDbd;
      new_cls    = ClsDbg;
    end else if (en_dbg && dbg_exc_req_i) begin
      grant[0]   = 1'b1;
      new_exc_pc = ExcPcDbe;
      new_cls    = ClsDbg;
    end else if (en_trap && exc_req_i) begin
      grant[1] = 1'b1;
      new_trap = {1'b0, trap_user_i};
      new_cls  = ClsTrap;
    end else if (en_trap && irq_req_i) begin
      grant[2]   = 1'b1;
      new_exc_pc = ExcPcIrq;
      new_trap   = {1'b0, trap_user_i};
      new_vec    = irq_id_i;
      new_cls    = ClsTrap;
    end else if (en_rest && dret_req_i) begin
      grant[3]   = 1'b1;
      new_pc_mux = PcDret;
    end else if (en_rest && mret_req_i) begin
      grant[4]   = 1'b1;
      new_pc_mux = PcMret;
    end else if (en_rest && uret_req_i) begin
      grant[5]   = 1'b1;
      new_pc_mux = PcUret;
    end else if (en_rest && branch_req_i) begin
      grant[6]   = 1'b1;
      new_pc_mux = PcBranch;
    end else if (en_rest && fencei_req_i) begin
      grant[7]   = 1'b1;
      new_pc_mux = PcFencei;
    end else if (en_rest && jump_req_i) begin
      grant[8]   = 1'b1;
      new_pc_mux = PcJump;
    end else if (en_rest && hwlp_req_i) begin
      grant[9]   = 1'b1;
      new_pc_mux = PcHwloop;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_set_d = pc_set_q;
    pc_mux_d = pc_mux_q;
    exc_pc_d = exc_pc_q;
    trap_d   = trap_q;
    vec_d    = vec_q;
    cls_d    = cls_q;
    cnt_d    = cnt_q;
    if (|grant) begin
      // A grant also covers ack-plus-preemption: the old command is simply replaced
      state_d  = StIssue;
      pc_set_d = 1'b1;
      pc_mux_d = new_pc_mux;
      exc_pc_d = new_exc_pc;
      trap_d   = new_trap;
      vec_d    = new_vec;
      cls_d    = new_cls;
      cnt_d    = '0;
    end else begin
      case (state_q)
        StBootWait: begin
          if (fetch_enable_i) begin
            state_d  = StIssue;
            pc_set_d = 1'b1;
            pc_mux_d = PcBoot;
            exc_pc_d = '0;
            trap_d   = '0;
            vec_d    = '0;
            cls_d    = ClsRest;
          end
        end
        StIssue: begin
          if (fetch_ack_i) begin
            pc_set_d = 1'b0;
            pc_mux_d = '0;
            exc_pc_d = '0;
            trap_d   = '0;
            vec_d    = '0;
            cls_d    = ClsRest;
            if (KILL_CYCLES == 0) begin
              state_d = StIdle;
            end else begin
              state_d = StKill;
              cnt_d   = CNT_W'(KILL_CYCLES);
            end
          end
        end
        StKill: begin
          if (cnt_q <= CNT_W'(1)) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StBootWait;
      pc_set_q <= 1'b0;
      pc_mux_q <= '0;
      exc_pc_q <= '0;
      trap_q   <= '0;
      vec_q    <= '0;
      cls_q    <= ClsRest;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_set_q <= pc_set_d;
      pc_mux_q <= pc_mux_d;
      exc_pc_q <= exc_pc_d;
      trap_q   <= trap_d;
      vec_q    <= vec_d;
      cls_q    <= cls_d;
      cnt_q    <= cnt_d;
    end
  end

  assign pc_set_o        = pc_set_q;
  assign pc_mux_o        = pc_mux_q;
  assign exc_pc_mux_o    = exc_pc_q;
  assign trap_addr_mux_o = trap_q;
  assign exc_vec_o       = vec_q;
  assign req_grant_o     = grant;
  assign kill_o          = (state_q == StKill);
  assign busy_o          = pc_set_q & ~fetch_ack_i;

endmodule

// File: tb/tb_cv32e40p_pc_redirect_sequencer.sv
// Randomized bench for the PC redirect sequencer against a transaction-level model
// built from a priority table, plus directed boot/preemption/kill/reset scenarios.
module tb_cv32e40p_pc_redirect_sequencer;

  localparam int unsigned KillCycles = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       fetch_enable_i, dbg_halt_req_i, dbg_exc_req_i, exc_req_i, irq_req_i;
  logic [4:0] irq_id_i;
  logic       trap_user_i, branch_req_i, jump_req_i, mret_req_i, uret_req_i, dret_req_i;
  logic       fencei_req_i, hwlp_req_i, fetch_ack_i;
  logic       pc_set_o, kill_o, busy_o;
  logic [3:0] pc_mux_o;
  logic [2:0] exc_pc_mux_o;
  logic [1:0] trap_addr_mux_o;
  logic [4:0] exc_vec_o;
  logic [9:0] req_grant_o;

  always #5 clk = ~clk;

  cv32e40p_pc_redirect_sequencer #(
    .KILL_CYCLES(KillCycles),
    .CNT_W      (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_enable_i (fetch_enable_i),
    .dbg_halt_req_i (dbg_halt_req_i),
    .dbg_exc_req_i  (dbg_exc_req_i),
    .exc_req_i      (exc_req_i),
    .irq_req_i      (irq_req_i),
    .irq_id_i       (irq_id_i),
    .trap_user_i    (trap_user_i),
    .branch_req_i   (branch_req_i),
    .jump_req_i     (jump_req_i),
    .mret_req_i     (mret_req_i),
    .uret_req_i     (uret_req_i),
    .dret_req_i     (dret_req_i),
    .fencei_req_i   (fencei_req_i),
    .hwlp_req_i     (hwlp_req_i),
    .fetch_ack_i    (fetch_ack_i),
    .pc_set_o       (pc_set_o),
    .pc_mux_o       (pc_mux_o),
    .exc_pc_mux_o   (exc_pc_mux_o),
    .trap_addr_mux_o(trap_addr_mux_o),
    .exc_vec_o      (exc_vec_o),
    .req_grant_o    (req_grant_o),
    .kill_o         (kill_o),
    .busy_o         (busy_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Model: whether booted, whether a command is outstanding, and kill cycles left
  bit         m_booted, m_have;
  int         m_cls, m_kill_left;
  logic [3:0] m_pc;
  logic [2:0] m_exc;
  logic [1:0] m_trap;
  logic [4:0] m_vec;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Requesters in priority order, index 0 highest
  function automatic logic [10:0] req_vec();
    return {hwlp_req_i, jump_req_i, fencei_req_i, branch_req_i, uret_req_i, mret_req_i,
            dret_req_i, irq_req_i, exc_req_i, dbg_exc_req_i, dbg_halt_req_i};
  endfunction

  function automatic int cls_of(input int i);
    if (i < 2) return 2;
    if (i < 4) return 1;
    return 0;
  endfunction

  function automatic logic [3:0] pc_of(input int i);
    case (i)
      0, 1, 2, 3: return 4'd4;
      4:          return 4'd7;
      5:          return 4'd5;
      6:          return 4'd6;
      7:          return 4'd3;
      8:          return 4'd1;
      9:          return 4'd2;
      default:    return 4'd8;
    endcase
  endfunction

  function automatic logic [2:0] excpc_of(input int i);
    case (i)
      0:       return 3'd2;
      1:       return 3'd3;
      3:       return 3'd1;
      default: return 3'd0;
    endcase
  endfunction

  function automatic int winner();
    logic [10:0] r;
    int          min_cls;
    r = req_vec();
    if (!m_booted) return -1;
    if (m_have) min_cls = m_cls + 1;
    else if (m_kill_left > 0) min_cls = 1;
    else min_cls = 0;
    for (int i = 0; i < 11; i++) if (r[i] && cls_of(i) >= min_cls) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_booted = 1'b0; m_have = 1'b0; m_cls = 0; m_kill_left = 0;
    m_pc = '0; m_exc = '0; m_trap = '0; m_vec = '0;
  endtask

  task automatic clear_inputs();
    fetch_enable_i = 1'b0; dbg_halt_req_i = 1'b0; dbg_exc_req_i = 1'b0; exc_req_i = 1'b0;
    irq_req_i = 1'b0; irq_id_i = '0; trap_user_i = 1'b0; branch_req_i = 1'b0;
    jump_req_i = 1'b0; mret_req_i = 1'b0; uret_req_i = 1'b0; dret_req_i = 1'b0;
    fencei_req_i = 1'b0; hwlp_req_i = 1'b0; fetch_ack_i = 1'b0;
  endtask

  task automatic check_regs();
    check("pc_set", 32'(pc_set_o), 32'(m_have));
    check("pc_mux", 32'(pc_mux_o), 32'(m_pc));
    check("exc_pc_mux", 32'(exc_pc_mux_o), 32'(m_exc));
    check("trap_addr_mux", 32'(trap_addr_mux_o), 32'(m_trap));
    check("exc_vec", 32'(exc_vec_o), 32'(m_vec));
    check("kill", 32'(kill_o), 32'(m_kill_left > 0));
  endtask

  // Called just after a falling edge with inputs already applied
  task automatic cycle();
    int         w;
    logic [9:0] g;
    #1;
    w = winner();
    g = '0;
    if (w >= 0) g[(w < 2) ? 0 : w - 1] = 1'b1;
    check("grant", 32'(req_grant_o), 32'(g));
    check("busy", 32'(busy_o), 32'(m_have && !fetch_ack_i));
    if (!m_booted) begin
      if (fetch_enable_i) begin
        m_booted = 1'b1; m_have = 1'b1; m_cls = 0;
        m_pc = '0; m_exc = '0; m_trap = '0; m_vec = '0;
      end
    end else if (w >= 0) begin
      m_have = 1'b1; m_cls = cls_of(w); m_kill_left = 0;
      m_pc = pc_of(w); m_exc = excpc_of(w);
      m_trap = (w == 2 || w == 3) ? {1'b0, trap_user_i} : 2'd0;
      m_vec = (w == 3) ? irq_id_i : 5'd0;
    end else if (m_have && fetch_ack_i) begin
      m_have = 1'b0; m_cls = 0; m_kill_left = KillCycles;
      m_pc = '0; m_exc = '0; m_trap = '0; m_vec = '0;
    end else if (m_kill_left > 0) begin
      m_kill_left--;
    end
    @(posedge clk);
    #1;
    check_regs();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_pc_set", 32'(pc_set_o), 32'd0);
    check("rst_pc_mux", 32'(pc_mux_o), 32'd0);
    check("rst_exc_pc_mux", 32'(exc_pc_mux_o), 32'd0);
    check("rst_trap", 32'(trap_addr_mux_o), 32'd0);
    check("rst_vec", 32'(exc_vec_o), 32'd0);
    check("rst_kill", 32'(kill_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    model_reset();
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      clear_inputs();
      fetch_enable_i = 1'b1;
      cycle();
    end
  endtask

  initial begin
    clear_inputs();
    model_reset();
    do_reset();

    // Boot: fetch enable raised on the third cycle, ack delayed by two cycles
    cycle();
    cycle();
    fetch_enable_i = 1'b1;
    cycle();
    check("boot_pc_set", 32'(pc_set_o), 32'd1);
    check("boot_pc_mux", 32'(pc_mux_o), 32'd0);
    idle_cycles(2);
    check("boot_hold", 32'(pc_set_o), 32'd1);
    fetch_ack_i = 1'b1;
    cycle();
    check("boot_cleared", 32'(pc_set_o), 32'd0);
    idle_cycles(2);

    // Branch beats jump
    branch_req_i = 1'b1; jump_req_i = 1'b1;
    cycle();
    check("branch_win", 32'(pc_mux_o), 32'd3);
    clear_inputs(); fetch_enable_i = 1'b1; fetch_ack_i = 1'b1;
    cycle();

    // Kill window: branch dropped, exception accepted and aborts the window
    clear_inputs(); fetch_enable_i = 1'b1; branch_req_i = 1'b1;
    cycle();
    check("kill_drop_branch", 32'(pc_set_o), 32'd0);
    clear_inputs(); fetch_enable_i = 1'b1; exc_req_i = 1'b1;
    cycle();
    check("kill_exc_mux", 32'(pc_mux_o), 32'd4);
    check("kill_exc_abort", 32'(kill_o), 32'd0);
    clear_inputs(); fetch_enable_i = 1'b1; fetch_ack_i = 1'b1;
    cycle();
    idle_cycles(2);

    // Interrupt command fields
    irq_req_i = 1'b1; irq_id_i = 5'd11; trap_user_i = 1'b1;
    cycle();
    check("irq_pc_mux", 32'(pc_mux_o), 32'd4);
    check("irq_exc_pc", 32'(exc_pc_mux_o), 32'd1);
    check("irq_trap", 32'(trap_addr_mux_o), 32'd1);
    check("irq_vec", 32'(exc_vec_o), 32'd11);
    clear_inputs(); fetch_enable_i = 1'b1; fetch_ack_i = 1'b1;
    cycle();
    idle_cycles(2);

    // Debug halt preempts a held jump without an ack
    jump_req_i = 1'b1;
    cycle();
    idle_cycles(1);
    dbg_halt_req_i = 1'b1;
    cycle();
    check("dbg_pc_mux", 32'(pc_mux_o), 32'd4);
    check("dbg_exc_pc", 32'(exc_pc_mux_o), 32'd2);
    check("dbg_pc_set", 32'(pc_set_o), 32'd1);

    // Reset while issuing, then the boot redirect again
    do_reset();
    fetch_enable_i = 1'b1;
    cycle();
    check("reboot_pc_set", 32'(pc_set_o), 32'd1);
    check("reboot_pc_mux", 32'(pc_mux_o), 32'd0);

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      fetch_enable_i = ($urandom_range(0, 3) != 0);
      dbg_halt_req_i = ($urandom_range(0, 15) == 0);
      dbg_exc_req_i  = ($urandom_range(0, 15) == 0);
      exc_req_i      = ($urandom_range(0, 9) == 0);
      irq_req_i      = ($urandom_range(0, 9) == 0);
      irq_id_i       = 5'($urandom_range(0, 31));
      trap_user_i    = 1'($urandom_range(0, 1));
      branch_req_i   = ($urandom_range(0, 5) == 0);
      jump_req_i     = ($urandom_range(0, 5) == 0);
      mret_req_i     = ($urandom_range(0, 7) == 0);
      uret_req_i     = ($urandom_range(0, 7) == 0);
      dret_req_i     = ($urandom_range(0, 7) == 0);
      fencei_req_i   = ($urandom_range(0, 7) == 0);
      hwlp_req_i     = ($urandom_range(0, 7) == 0);
      fetch_ack_i    = 1'($urandom_range(0, 1));
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cv32e40p_pc_redirect_sequencer.md
Name: cv32e40p_pc_redirect_sequencer

Overview:
- Arbitrates all PC-redirect requesters (debug, exceptions, interrupts, branch, jump, xRET, fence.i, hardware loop) into one registered redirect command.
- The command drives the fetch-address selection datapath: pc_mux, exc_pc_mux, trap_addr_mux, vector index and pc_set.
- Holds the command until the fetch stage acknowledges it, issues the boot redirect after reset, and suppresses requests for a programmable kill window after each redirect.
- Sits between the ID-stage controller and the IF stage.

Parameters:
- KILL_CYCLES, 2, number of cycles after a redirect ack during which non-debug, non-exception requests are dropped (0 = no window).
- CNT_W, 2, counter width; must satisfy 2^CNT_W > KILL_CYCLES.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- fetch_enable_i  in  1  core fetch enable; gates the boot redirect
- dbg_halt_req_i  in  1  debug halt request (EXC_PC_DBD)
- dbg_exc_req_i  in  1  exception while in debug mode (EXC_PC_DBE)
- exc_req_i  in  1  synchronous exception
- irq_req_i  in  1  interrupt taken
- irq_id_i  in  5  interrupt vector index
- trap_user_i  in  1  trap targets user mode (TRAP_USER) else TRAP_MACHINE
- branch_req_i  in  1  EX branch taken
- jump_req_i  in  1  ID jump
- mret_req_i, uret_req_i, dret_req_i  in  1 each  return requests
- fencei_req_i  in  1  fence.i
- hwlp_req_i  in  1  hardware-loop branch
- fetch_ack_i  in  1  IF accepts the current redirect
- pc_set_o  out  1  redirect valid
- pc_mux_o  out  4  PC_* selector
- exc_pc_mux_o  out  3  EXC_PC_* selector
- trap_addr_mux_o  out  2  TRAP_MACHINE/TRAP_USER
- exc_vec_o  out  5  vector index for IRQ
- req_grant_o  out  10  one-hot grant, bit order = priority list below (bit0 = dbg_halt)
- kill_o  out  1  kill window active
- busy_o  out  1  redirect pending (pc_set_o & ~fetch_ack_i)

Behaviour:
- Encodings: PC_BOOT=0, PC_FENCEI=1, PC_JUMP=2, PC_BRANCH=3, PC_EXCEPTION=4, PC_MRET=5, PC_URET=6, PC_DRET=7, PC_HWLOOP=8. EXC_PC_EXCEPTION=0, EXC_PC_IRQ=1, EXC_PC_DBD=2, EXC_PC_DBE=3. TRAP_MACHINE=0, TRAP_USER=1.
- Reset: state BOOT_WAIT. All outputs are 0, and kill counter = 0.
- FSM states:
  - BOOT_WAIT: on fetch_enable_i, register pc_set=1, pc_mux=PC_BOOT, and go to ISSUE.
  - IDLE: on any granted request, register the command next cycle (1-cycle latency), set pc_set_o=1, and go to ISSUE.
  - ISSUE: outputs held stable while fetch_ack_i=0. On fetch_ack_i, the next cycle clears pc_set_o, loads kill counter = KILL_CYCLES and goes to KILL (or IDLE if KILL_CYCLES=0).
  - KILL: kill_o=1 and the counter decrements each cycle; at 1, go to IDLE. Debug/exception/irq requests are still granted in KILL and abort the window.
- Priority, highest first: dbg_halt, dbg_exc, exc, irq, dret, mret, uret, branch, fencei, jump, hwlp.
  - dbg_halt and dbg_exc share grant bit0; the 10-bit grant covers 11 requesters, and dbg_exc is reported on bit0.
  - Only the winner is granted. Losers are not latched; requesters must re-assert.
- Command fields:
  - exc/irq/dbg set pc_mux=PC_EXCEPTION.
  - exc_pc_mux is DBD/DBE/EXCEPTION/IRQ respectively.
  - trap_addr_mux = trap_user_i for exc/irq; TRAP_MACHINE for debug.
  - exc_vec_o = irq_id_i for irq, else 0.
  - Non-exception commands set exc_pc_mux=0, trap_addr_mux=0, exc_vec_o=0.
- Preemption in ISSUE: a request of strictly higher class (debug > exception/irq > rest) replaces the held command in the next cycle without an ack. Equal or lower classes are ignored.
- Simultaneous ack and higher-class request: the ack completes the old command, and the new command issues the next cycle (old is not replayed).
- req_grant_o is a combinational pulse in the request cycle and is zero in BOOT_WAIT.
- Reset mid-ISSUE returns to BOOT_WAIT immediately; the pending command is lost.

Test Plan:
- Reset, then fetch_enable_i=1 at cycle 3: pc_set_o=1 and pc_mux_o=0 at cycle 4; hold through a 2-cycle ack delay; pc_set_o=0 the cycle after ack.
- branch_req_i and jump_req_i in the same cycle in IDLE: grant on branch, pc_mux_o=3, jump dropped.
- irq_req_i with irq_id_i=5'd11 and trap_user_i=1: pc_mux_o=4, exc_pc_mux_o=1, trap_addr_mux_o=1, exc_vec_o=11.
- In ISSUE holding PC_JUMP with no ack, pulse dbg_halt_req_i: the next cycle shows pc_mux_o=4 and exc_pc_mux_o=2, with pc_set_o continuously 1.
- KILL_CYCLES=2: after ack, kill_o=1 for exactly 2 cycles, and branch_req_i inside the window is not granted. exc_req_i inside the window is granted and kill_o drops.
- Assert rst while in ISSUE: all outputs 0 asynchronously and state BOOT_WAIT; the boot redirect re-issues after fetch_enable_i.
